// File: rtl/uart_ascii_pkg.sv
// Shared ASCII constants and parser state type for the UART number
// parser (uart_ascii2num) and its number-to-ASCII formatter counterpart.
package uart_ascii_pkg;

  localparam logic [7:0] ASCII_0     = 8'd48;
  localparam logic [7:0] ASCII_9     = 8'd57;
  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_LF    = 8'd10;
  localparam logic [7:0] ASCII_QMARK = 8'd63;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DISCARD = 2'd2
  } parse_state_e;

endpackage

// File: rtl/uart_ascii_classify.sv
// Combinational byte classifier: decimal digit, line terminator, or neither.
module uart_ascii_classify
  import uart_ascii_pkg::*;
(
  input  logic [7:0] rx_byte,
  output logic       is_digit,
  output logic       is_term,
  output logic [3:0] digit_val
);

  logic [7:0] offset_s;

  // Digit value is only meaningful when is_digit is set; forced to zero otherwise.
  always_comb begin
    offset_s  = rx_byte - ASCII_0;
    is_digit  = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
    is_term   = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
    if (is_digit) begin
      digit_val = offset_s[3:0];
    end else begin
      digit_val = 4'd0;
    end
  end

endmodule

// File: rtl/uart_ascii2num.sv
// Parses CR/LF-terminated decimal ASCII lines into an unsigned WIDTH-bit value.
// Optional character echo is enabled by defining UART_ASCII2NUM_ECHO_EN.
module uart_ascii2num
  import uart_ascii_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] num,
  output logic             num_valid,
  output logic             num_err
`ifdef UART_ASCII2NUM_ECHO_EN
  ,
  output logic [7:0]       echo_data,
  output logic             echo_valid
`endif
);

  logic             is_digit_s;
  logic             is_term_s;
  logic [3:0]       digit_val_s;
  logic [WIDTH+3:0] acc_next_s;
  logic             overflow_s;

  parse_state_e     state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             num_valid_q, num_valid_d;
  logic             num_err_q, num_err_d;
`ifdef UART_ASCII2NUM_ECHO_EN
  logic [7:0]       echo_data_q, echo_data_d;
  logic             echo_valid_q, echo_valid_d;
`endif

  uart_ascii_classify u_classify (
    .rx_byte   (rx_data),
    .is_digit  (is_digit_s),
    .is_term   (is_term_s),
    .digit_val (digit_val_s)
  );

  // acc*10 + digit at WIDTH+4 bits; any bit above WIDTH-1 means overflow.
  always_comb begin
    acc_next_s = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1)
               + {{WIDTH{1'b0}}, digit_val_s};
    overflow_s = |acc_next_s[WIDTH+3:WIDTH];
  end

  // Next-state, accumulator and output pulse computation.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    num_d       = num_q;
    num_valid_d = 1'b0;
    num_err_d   = 1'b0;
`ifdef UART_ASCII2NUM_ECHO_EN
    echo_valid_d = 1'b0;
    echo_data_d  = echo_data_q;
`endif
    if (rx_valid) begin
`ifdef UART_ASCII2NUM_ECHO_EN
      echo_valid_d = 1'b1;
      if (is_term_s || (is_digit_s && (state_q == ST_IDLE))
          || (is_digit_s && (state_q == ST_ACCUM) && !overflow_s)) begin
        echo_data_d = rx_data;
      end else begin
        echo_data_d = ASCII_QMARK;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (is_digit_s) begin
            acc_d   = {{(WIDTH-4){1'b0}}, digit_val_s};
            state_d = ST_ACCUM;
          end else if (!is_term_s) begin
            acc_d   = '0;
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (is_digit_s && !overflow_s) begin
            acc_d = acc_next_s[WIDTH-1:0];
          end else if (is_term_s) begin
            num_d       = acc_q;
            num_valid_d = 1'b1;
            acc_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            acc_d   = '0;
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (is_term_s) begin
            num_err_d = 1'b1;
            acc_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        default: begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
      num_err_q   <= 1'b0;
`ifdef UART_ASCII2NUM_ECHO_EN
      echo_data_q  <= 8'd0;
      echo_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      num_err_q   <= num_err_d;
`ifdef UART_ASCII2NUM_ECHO_EN
      echo_data_q  <= echo_data_d;
      echo_valid_q <= echo_valid_d;
`endif
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign num_err   = num_err_q;
`ifdef UART_ASCII2NUM_ECHO_EN
  assign echo_data  = echo_data_q;
  assign echo_valid = echo_valid_q;
`endif

endmodule

// File: tb/tb_uart_ascii2num.sv
// Self-checking bench for uart_ascii2num (WIDTH=16): table of lines plus
// hand-written timing, reset and (with UART_ASCII2NUM_ECHO_EN) echo sequences.
module tb_uart_ascii2num;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] num;
  logic             num_valid;
  logic             num_err;
`ifdef UART_ASCII2NUM_ECHO_EN
  logic [7:0]       echo_data;
  logic             echo_valid;
  logic [7:0]       echo_q[$];
`endif

  int tests;
  int fails;
  int valid_cnt;
  int err_cnt;

  typedef struct {
    logic [63:0] chars;
    int          len;
    int          exp_valid;
    int          exp_err;
    int          exp_num;
  } vec_t;

  vec_t vecs[13];

  uart_ascii2num #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .num       (num),
    .num_valid (num_valid),
    .num_err   (num_err)
`ifdef UART_ASCII2NUM_ECHO_EN
    ,
    .echo_data  (echo_data),
    .echo_valid (echo_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (num_valid) valid_cnt++;
    if (num_err) err_cnt++;
    if (num_valid && num_err) begin
      fails++;
      $display("FAIL pulse_exclusive: num_valid=1 and num_err=1 together at %0t", $time);
    end
`ifdef UART_ASCII2NUM_ECHO_EN
    if (echo_valid) echo_q.push_back(echo_data);
`endif
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h31;
    end
  endtask

  task automatic send_chars(input logic [63:0] ch, input int len);
    for (int i = 0; i < len; i++) send_byte(ch[8*(len-1-i) +: 8]);
  endtask

  initial begin
    tests = 0; fails = 0; valid_cnt = 0; err_cnt = 0;
    rx_data = 8'd0; rx_valid = 1'b0; rst_n = 1'b0;

    vecs[0]  = '{64'("123\r"),    4, 1, 0, 123};
    vecs[1]  = '{64'("65535\n"),  6, 1, 0, 65535};
    vecs[2]  = '{64'("65536\n"),  6, 0, 1, 65535};
    vecs[3]  = '{64'("12a4\r\n"), 6, 0, 1, 65535};
    vecs[4]  = '{64'("9\r"),      2, 1, 0, 9};
    vecs[5]  = '{64'("\r\n\r"),   3, 0, 0, 9};
    vecs[6]  = '{64'("007\r\n"),  5, 1, 0, 7};
    vecs[7]  = '{64'("0\r"),      2, 1, 0, 0};
    vecs[8]  = '{64'("x\r"),      2, 0, 1, 0};
    vecs[9]  = '{64'("99999\r"),  6, 0, 1, 0};
    vecs[10] = '{64'("6553\n"),   5, 1, 0, 6553};
    vecs[11] = '{64'("70000\r"),  6, 0, 1, 6553};
    vecs[12] = '{64'("1\r2\r"),   4, 2, 0, 2};

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset_num", int'(num), 0);
    check("reset_valid", int'(num_valid), 0);
    check("reset_err", int'(num_err), 0);
`ifdef UART_ASCII2NUM_ECHO_EN
    check("reset_echo_valid", int'(echo_valid), 0);
    check("reset_echo_data", int'(echo_data), 0);
`endif
    rst_n = 1'b1;
    idle(2);

    // Cycle-exact "123\r": pulse only in the cycle after the CR strobe.
    send_byte(8'd49);
    send_byte(8'd50);
    send_byte(8'd51);
    send_byte(8'd13);
    check("t123_no_early_valid", int'(num_valid), 0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("t123_valid_n1", int'(num_valid), 1);
    check("t123_num_n1", int'(num), 123);
    check("t123_err_n1", int'(num_err), 0);
    @(negedge clk);
    check("t123_valid_n2", int'(num_valid), 0);
    check("t123_num_held", int'(num), 123);
    idle(2);

    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      valid_cnt = 0;
      err_cnt   = 0;
      send_chars(vecs[v].chars, vecs[v].len);
      idle(3);
      check($sformatf("vec%0d_valid_cnt", v), valid_cnt, vecs[v].exp_valid);
      check($sformatf("vec%0d_err_cnt", v), err_cnt, vecs[v].exp_err);
      check($sformatf("vec%0d_num", v), int'(num), vecs[v].exp_num);
    end

    // Reset mid-line drops the partial number.
    @(negedge clk);
    valid_cnt = 0;
    err_cnt   = 0;
    send_byte(8'd52);
    send_byte(8'd53);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("rst_mid_num", int'(num), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'd54);
    send_byte(8'd13);
    idle(3);
    check("rst_mid_valid_cnt", valid_cnt, 1);
    check("rst_mid_err_cnt", err_cnt, 0);
    check("rst_mid_num_after", int'(num), 6);

`ifdef UART_ASCII2NUM_ECHO_EN
    echo_q.delete();
    send_chars(64'("4x\r"), 3);
    idle(3);
    check("echo_count", echo_q.size(), 3);
    if (echo_q.size() == 3) begin
      check("echo_0", int'(echo_q[0]), 52);
      check("echo_1", int'(echo_q[1]), 63);
      check("echo_2", int'(echo_q[2]), 13);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_ascii2num.md
# uart_ascii2num

Parses a stream of ASCII characters from the buffered UART receive path into an unsigned binary number. Consumes one received byte per strobe, accumulates decimal digits, and on a line terminator (CR or LF) presents the value with a one-cycle valid pulse, or an error pulse for malformed or overflowing input. It is the receive-side counterpart of the number-to-ASCII formatter and sits between the UART RX byte interface and command logic.

## Interface
- WIDTH, 16: result width in bits; legal range 4..32.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; sampled only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per byte; no backpressure, block must accept every strobe.
- num  out  WIDTH  last successfully parsed value; held until the next num_valid.
- num_valid  out  1  one-cycle pulse, num updated in the same cycle.
- num_err  out  1  one-cycle pulse: line discarded.
- echo_data  out  8  echoed character (only with UART_ASCII2NUM_ECHO_EN).
- echo_valid  out  1  one-cycle echo strobe (only with UART_ASCII2NUM_ECHO_EN).

## Operation
- Classification: digit = 48..57 (value = byte-48); terminator = 13 (CR) or 10 (LF); anything else is illegal.
- States: IDLE (no digits yet), ACCUM (>=1 digit held), DISCARD (line bad, waiting for terminator).
- IDLE: digit -> acc=value, ACCUM; terminator -> ignored, stay IDLE (so CR LF and empty lines produce nothing); illegal -> DISCARD.
- ACCUM: digit -> acc=acc*10+value if the result is <= 2^WIDTH-1, else DISCARD; terminator -> num=acc, num_valid pulse, IDLE; illegal -> DISCARD.
- DISCARD: terminator -> num_err pulse, IDLE; all other bytes ignored.
- Arithmetic: acc*10+value computed at WIDTH+4 bits; overflow = any bit above WIDTH-1 set. acc is WIDTH bits and is cleared on entry to IDLE.
- Leading zeros are legal ("007" -> 7); digit count is bounded only by overflow.
- num_valid and num_err are never asserted together.

## Timing
- Reset values: num=0, num_valid=0, num_err=0, echo_data=0, echo_valid=0, state=IDLE, acc=0.
- Byte accepted in cycle N (rx_valid=1) -> state/acc updated at the end of N; num_valid or num_err high in cycle N+1 only.
- Back-to-back rx_valid on consecutive cycles is supported at full rate; a terminator in N followed by a digit in N+1 starts a new number with no loss.
- Reset asserted mid-line: the partial number is dropped and no pulse is issued; num returns to 0. The first byte after deassertion is treated as the start of a line.
- rx_data is ignored whenever rx_valid=0.

## Configuration
- UART_ASCII2NUM_ECHO_EN defined: echo_data/echo_valid ports exist. For every accepted byte in cycle N, echo_valid pulses in N+1. echo_data is rx_data for a digit or terminator, and 63 ('?') for an illegal or overflow-causing byte. Bytes ignored while in DISCARD echo as '?'. Output feeds the TX FIFO, which has no ready signal.
- Undefined: echo ports and logic are absent; parse behaviour is identical.

## Structure
- Shared package uart_ascii_pkg: constants ASCII_0 (48), ASCII_9 (57), ASCII_CR (13), ASCII_LF (10), ASCII_QMARK (63), and the state enum typedef. The formatter uses the same constants.
- One combinational sub-module, uart_ascii_classify: byte in; is_digit, is_term and digit value (4 bits) out.
- The FSM and accumulator live in the top module.

## Test plan
- Send "123\r" at full rate -> num=123 and num_valid for one cycle, one cycle after the CR strobe; num_err stays 0.
- WIDTH=16: send "65535\n" -> num=65535 valid. Then send "65536\n" -> num_err pulse, num stays 65535.
- Send "12a4\r\n" -> a single num_err on the CR and nothing on the LF. A following "9\r" -> num=9.
- Send "\r\n\r" -> no pulses. Send "007\r\n" -> exactly one num_valid, num=7.
- Send "45", assert rst_n low for 2 cycles, then send "6\r" -> num=6, no pulse during or after reset. With UART_ASCII2NUM_ECHO_EN defined, "4x\r" echoes 52, 63, 13.
